qc_shift_scheduler: RTL and testbench
=====================================

// Module: qc_shift_scheduler
// PURPOSE
// Sequences one base-matrix row through the pipelined circular shifter (pipelinedCircularShifter1/2).
// For each of num_cols columns it:
//   - fetches the shift entry and the Z-bit block from the base-matrix/block memory;
//   - drives the shifter inputs;
//   - tags the in-flight token with its column index;
//   - captures the shifter output LATENCY cycles later into a credit-protected result FIFO.
// Sits between the decoder row controller and the check-node datapath.
// PARAMETERS
// MAXZ        8    lifting size; shifter data width
// LATENCY     16   shifter cycles from input register update to valid sh_out_data (>=1)
// MAX_COLS    24   maximum base-matrix columns per row
// FIFO_DEPTH  4    result FIFO entries (>=1); issue credits = FIFO_DEPTH
// COLW        $clog2(MAX_COLS)  derived; column index width
// PORTS
// CLK           in   1            clock, rising edge
// rst_n         in   1            asynchronous active-low reset
// start         in   1            1-cycle pulse; begins a row; ignored while busy=1
// num_cols      in   COLW+1       columns in row, sampled on accepted start
// busy          out  1            high from accepted start until done
// done          out  1            1-cycle pulse after last result popped
// bm_rd         out  1            memory read strobe
// bm_addr       out  COLW         column being read
// bm_shift      in   $clog2(MAXZ) shift entry, valid cycle after bm_rd
// bm_null       in   1            1 = zero block (base entry -1), valid cycle after bm_rd
// blk_data      in   MAXZ         block data, valid cycle after bm_rd
// sh_in_data    out  MAXZ         registered shifter data input
// sh_shift_val  out  $clog2(MAXZ) registered shifter shift input
// sh_out_data   in   MAXZ         shifter output
// res_valid     out  1            FIFO head valid
// res_ready     in   1            downstream accept; pop when res_valid&res_ready
// res_col       out  COLW         column index of head
// res_data      out  MAXZ         rotated block at head
// BEHAVIOUR
// Reset (async, rst_n=0) values:
//   - all outputs 0;
//   - FSM=IDLE;
//   - FIFO empty, credits=FIFO_DEPTH;
//   - tag pipe cleared.
// Reset mid-row discards all in-flight tokens and FIFO contents.
// FSM:
//   - IDLE: start -> busy=1, col=0, n=min(num_cols,MAX_COLS); n==0 -> DONE, else FETCH.
//   - FETCH: bm_rd=1, bm_addr=col for exactly one cycle -> ISSUE.
//   - ISSUE: memory outputs held valid until consumed.
//       - If credits>0: update sh_in_data/sh_shift_val, push tag {col}, credits--.
//           - bm_null=1 drives sh_in_data=0, sh_shift_val=0.
//           - Then col==n-1 -> DRAIN, else col++ and -> FETCH.
//       - If credits==0: stall in ISSUE, sh_* hold value.
//   - DRAIN: wait until tag pipe empty and FIFO empty -> DONE.
//   - DONE: done=1 one cycle, busy=0 -> IDLE.
// Throughput: one column per 2 cycles when unstalled.
// Tag pipe:
//   - a token whose sh_* registers update on edge E is written into the FIFO at edge E+LATENCY,
//     with res_data=sh_out_data sampled at that edge;
//   - one token per slot; results leave in column order.
// Credits:
//   - +1 on each pop; -1 on each issue;
//   - a simultaneous pop and issue leaves credits unchanged;
//   - guarantees the FIFO never overflows, so no capture is ever dropped.
// FIFO: first-word fall-through; a push into an empty FIFO gives res_valid on the next cycle.
// sh_* outputs retain the last issued value between tokens and after done.
// CONFIGURATION
// QC_SCHED_STALL_CNT_EN defined:
//   - adds output stall_cnt[15:0];
//   - counts ISSUE cycles blocked by credits==0; saturates at 16'hFFFF;
//   - cleared to 0 on accepted start and on reset.
// QC_SCHED_STALL_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.
// TESTING
// 1. Reset, start with num_cols=3, shifts {1,3,0}, blocks {8'b10110101,8'h0F,8'hF0}, res_ready=1.
//    Required: results col0=8'b11011010, col1=8'hE1, col2=8'hF0, in that order;
//    then a single done pulse; busy=0.
// 2. start with num_cols=0. Required: no bm_rd, done=1 exactly 2 cycles after start, no res_valid.
// 3. num_cols=8, res_ready=0 until 40 cycles after start.
//    Required:
//      - exactly 4 issues, then ISSUE stalls;
//      - FIFO holds 4 results;
//      - after res_ready=1, all 8 results arrive in order, correct;
//      - stall_cnt>0 when QC_SCHED_STALL_CNT_EN is defined.
// 4. Column 1 has bm_null=1, blk_data=8'hFF. Required: res_data for col1 is 8'h00.
// 5. Pulse start again while busy. Required: ignored; row results and the number of done pulses unchanged.
// 6. Assert rst_n=0 mid-row with 3 tokens in flight.
//    Required: outputs 0 immediately, no stale res_valid after release;
//    a new row of 2 columns completes correctly.

Source files
------------

// File: rtl/qc_shift_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : qc_shift_scheduler
// Purpose  : Feeds one base-matrix row through an external pipelined
//            circular shifter. Each column goes through four steps: fetch the
//            shift entry and block, drive the shifter, tag the in-flight
//            token, then capture the rotated block into a credit-protected
//            first-word-fall-through result FIFO.
// Options  : QC_SCHED_STALL_CNT_EN adds a saturating stall_cnt[15:0] output
//            that counts ISSUE cycles blocked by lack of credits.
// Revision : 1.0 - initial release
// ============================================================================
module qc_shift_scheduler #(
    parameter int MAXZ       = 8,
    parameter int LATENCY    = 16,
    parameter int MAX_COLS   = 24,
    parameter int FIFO_DEPTH = 4,
    localparam int COLW      = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1,
    localparam int SW        = (MAXZ > 1) ? $clog2(MAXZ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [COLW:0]     num_cols,
    output logic              busy,
    output logic              done,
    output logic              bm_rd,
    output logic [COLW-1:0]   bm_addr,
    input  logic [SW-1:0]     bm_shift,
    input  logic              bm_null,
    input  logic [MAXZ-1:0]   blk_data,
    output logic [MAXZ-1:0]   sh_in_data,
    output logic [SW-1:0]     sh_shift_val,
    input  logic [MAXZ-1:0]   sh_out_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [COLW-1:0]   res_col,
    output logic [MAXZ-1:0]   res_data
`ifdef QC_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int NW = COLW + 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] C_DEPTH    = CW'(FIFO_DEPTH);
    localparam logic [NW-1:0] C_MAX_COLS = NW'(MAX_COLS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_busy;
    logic                r_done;
    logic [COLW-1:0]     r_col;
    logic [NW-1:0]       r_n;
    logic [CW-1:0]       r_credits;
    logic [MAXZ-1:0]     r_sh_data;
    logic [SW-1:0]       r_sh_shift;

    logic [LATENCY-1:0]  r_tag_v;
    logic [COLW-1:0]     r_tag_col [LATENCY];

    logic [COLW-1:0]     r_fifo_col  [FIFO_DEPTH];
    logic [MAXZ-1:0]     r_fifo_data [FIFO_DEPTH];
    logic [PW-1:0]       r_wr;
    logic [PW-1:0]       r_rd;
    logic [CW-1:0]       r_count;

    logic                w_start_ok;
    logic                w_last;
    logic [NW-1:0]       w_n_clip;
    logic                w_issue;
    logic                w_stall;
    logic                w_bm_rd;
    logic                w_push;
    logic                w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_start_ok = start && !r_busy && (r_state == S_IDLE);
    assign w_n_clip   = (num_cols > C_MAX_COLS) ? C_MAX_COLS : num_cols;
    assign w_last     = ({1'b0, r_col} == (r_n - NW'(1)));
    assign w_push     = r_tag_v[LATENCY-1];
    assign w_pop      = res_valid && res_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic plus the per-state strobes (fetch, issue, stall)
    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        w_stall = 1'b0;
        w_bm_rd = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_next = (w_n_clip == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                w_bm_rd = 1'b1;
                w_next  = S_ISSUE;
            end
            S_ISSUE: begin
                if (r_credits != '0) begin
                    w_issue = 1'b1;
                    w_next  = w_last ? S_DRAIN : S_FETCH;
                end else begin
                    w_stall = 1'b1;
                end
            end
            S_DRAIN: begin
                if ((r_tag_v == '0) && (r_count == '0)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign bm_rd   = w_bm_rd;
    assign bm_addr = w_bm_rd ? r_col : '0;

    // Row bookkeeping: busy/done flags, column counter and clipped row length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_col  <= '0;
            r_n    <= '0;
        end else begin
            r_done <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_busy <= 1'b0;
            end else if (w_start_ok) begin
                r_busy <= 1'b1;
            end
            if (w_start_ok) begin
                r_col <= '0;
                r_n   <= w_n_clip;
            end else if (w_issue && !w_last) begin
                r_col <= r_col + COLW'(1);
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;

    // Shifter input registers; a null base entry is sent as an all-zero block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_data  <= '0;
            r_sh_shift <= '0;
        end else if (w_issue) begin
            r_sh_data  <= bm_null ? '0 : blk_data;
            r_sh_shift <= bm_null ? '0 : bm_shift;
        end
    end

    assign sh_in_data   = r_sh_data;
    assign sh_shift_val = r_sh_shift;

    // Tag pipe: mirrors the shifter latency so the column tag and its
    // rotated block reach the capture point on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_tag_col[i] <= '0;
            end
        end else begin
            r_tag_v[0]   <= w_issue;
            r_tag_col[0] <= r_col;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag_v[i]   <= r_tag_v[i-1];
                r_tag_col[i] <= r_tag_col[i-1];
            end
        end
    end

    // Issue credits: one per free FIFO slot not already claimed by a token
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits <= C_DEPTH;
        end else begin
            case ({w_issue, w_pop})
                2'b10:   r_credits <= r_credits - CW'(1);
                2'b01:   r_credits <= r_credits + CW'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the entry is not counted
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_col[r_wr]  <= r_tag_col[LATENCY-1];
            r_fifo_data[r_wr] <= sh_out_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= ptr_inc(r_wr);
            end
            if (w_pop) begin
                r_rd <= ptr_inc(r_rd);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign res_valid = (r_count != '0);
    assign res_col   = res_valid ? r_fifo_col[r_rd]  : '0;
    assign res_data  = res_valid ? r_fifo_data[r_rd] : '0;

`ifdef QC_SCHED_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of credit-blocked ISSUE cycles, cleared per row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_start_ok) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    logic w_unused_stall;
    assign w_unused_stall = w_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_qc_shift_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_qc_shift_scheduler
// Purpose  : Self-checking bench for qc_shift_scheduler with a behavioural
//            base-matrix memory and a 16-cycle right-rotating shifter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qc_shift_scheduler;

    localparam int LATENCY = 16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  num_cols;
    logic        busy;
    logic        done;
    logic        bm_rd;
    logic [4:0]  bm_addr;
    logic [2:0]  bm_shift;
    logic        bm_null;
    logic [7:0]  blk_data;
    logic [7:0]  sh_in_data;
    logic [2:0]  sh_shift_val;
    logic [7:0]  sh_out_data;
    logic        res_valid;
    logic        res_ready;
    logic [4:0]  res_col;
    logic [7:0]  res_data;
`ifdef QC_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    qc_shift_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_cols     (num_cols),
        .busy         (busy),
        .done         (done),
        .bm_rd        (bm_rd),
        .bm_addr      (bm_addr),
        .bm_shift     (bm_shift),
        .bm_null      (bm_null),
        .blk_data     (blk_data),
        .sh_in_data   (sh_in_data),
        .sh_shift_val (sh_shift_val),
        .sh_out_data  (sh_out_data),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_col      (res_col),
        .res_data     (res_data)
`ifdef QC_SCHED_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Base-matrix / block memory: one-cycle read latency, output held
    logic [2:0] mem_shift [0:23];
    logic       mem_null  [0:23];
    logic [7:0] mem_blk   [0:23];

    always @(posedge clk) begin
        if (bm_rd) begin
            bm_shift <= mem_shift[bm_addr];
            bm_null  <= mem_null[bm_addr];
            blk_data <= mem_blk[bm_addr];
        end
    end

    // Shifter model: right rotation, result valid LATENCY edges after input
    function automatic logic [7:0] rotr(input logic [7:0] d, input logic [2:0] s);
        logic [15:0] t;
        t = {d, d} >> s;
        return t[7:0];
    endfunction

    logic [7:0] pipe [0:LATENCY-2];
    always @(posedge clk) begin
        pipe[0] <= rotr(sh_in_data, sh_shift_val);
        for (int i = 1; i < LATENCY - 1; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end
    assign sh_out_data = pipe[LATENCY-2];

    // Monitor: records popped results and counts events on the falling edge
    logic [12:0] res_q [$];
    int          done_cnt;
    int          bmrd_cnt;
    int          valid_cnt;
    initial begin
        done_cnt  = 0;
        bmrd_cnt  = 0;
        valid_cnt = 0;
    end
    always @(negedge clk) begin
        if (res_valid && res_ready) res_q.push_back({res_col, res_data});
        if (done)      done_cnt  <= done_cnt + 1;
        if (bm_rd)     bmrd_cnt  <= bmrd_cnt + 1;
        if (res_valid) valid_cnt <= valid_cnt + 1;
    end

    // Row vectors with hand-computed rotations
    typedef struct packed {
        logic [4:0]      ncols;
        logic [7:0]      nulls;
        logic [7:0][2:0] shift;
        logic [7:0][7:0] blk;
        logic [7:0][7:0] expd;
    } vec_t;

    localparam int NVEC = 6;
    vec_t vecs [0:NVEC-1];

    int total;
    int bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_col(input int v, input int k, input logic [2:0] sh,
                           input logic nl, input logic [7:0] b, input logic [7:0] e);
        vecs[v].shift[k] = sh;
        vecs[v].nulls[k] = nl;
        vecs[v].blk[k]   = b;
        vecs[v].expd[k]  = e;
    endtask

    task automatic load_row(input int v);
        for (int k = 0; k < 24; k++) begin
            mem_shift[k] = (k < 8) ? vecs[v].shift[k] : 3'd0;
            mem_null[k]  = (k < 8) ? vecs[v].nulls[k] : 1'b0;
            mem_blk[k]   = (k < 8) ? vecs[v].blk[k]   : 8'h00;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one row; optionally re-pulses start while busy and/or holds
    // res_ready low until rdelay cycles after start
    task automatic run_row(input int v, input bit extra, input int rdelay);
        int  base_q;
        int  base_done;
        int  base_rd;
        int  n;
        bit  seen;
        n         = int'(vecs[v].ncols);
        load_row(v);
        base_q    = res_q.size();
        base_done = done_cnt;
        base_rd   = bmrd_cnt;
        res_ready = (rdelay == 0);
        num_cols  = 6'(n);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        seen      = 1'b0;
        for (int c = 1; c < 600; c++) begin
            if (extra && c == 4) begin
                start    = 1'b1;
                num_cols = 6'd5;
            end else begin
                start = 1'b0;
            end
            if (rdelay > 0 && c == rdelay) begin
                check($sformatf("v%0d stall fetches", v), 32'(bmrd_cnt - base_rd), 32'd5);
                check($sformatf("v%0d fifo full valid", v), {31'd0, res_valid}, 32'd1);
                check($sformatf("v%0d no pops while held", v), 32'(res_q.size() - base_q), 32'd0);
`ifdef QC_SCHED_STALL_CNT_EN
                check($sformatf("v%0d stall_cnt nonzero", v), {31'd0, (stall_cnt != 16'd0)}, 32'd1);
`endif
                res_ready = 1'b1;
            end
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check($sformatf("v%0d done seen", v), {31'd0, seen}, 32'd1);
        check($sformatf("v%0d busy at done", v), {31'd0, busy}, 32'd0);
        tick();
        check($sformatf("v%0d done one cycle", v), {31'd0, done}, 32'd0);
        repeat (3) tick();
        check($sformatf("v%0d done pulses", v), 32'(done_cnt - base_done), 32'd1);
        check($sformatf("v%0d fetches", v), 32'(bmrd_cnt - base_rd), 32'(n));
        check($sformatf("v%0d result count", v), 32'(res_q.size() - base_q), 32'(n));
        if (res_q.size() - base_q == n) begin
            for (int k = 0; k < n; k++) begin
                check($sformatf("v%0d col%0d tag", v, k),
                      {27'd0, res_q[base_q+k][12:8]}, 32'(k));
                check($sformatf("v%0d col%0d data", v, k),
                      {24'd0, res_q[base_q+k][7:0]}, {24'd0, vecs[v].expd[k]});
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int base_q;
        int base_rd;
        int base_v;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        num_cols  = 6'd0;
        res_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) vecs[i] = '0;

        // v0: basic row; v1: null column 1; v2: 4 columns; v3: 2 columns;
        // v4: 8 columns for the credit stall; v5: single column
        vecs[0].ncols = 5'd3;
        set_col(0, 0, 3'd1, 1'b0, 8'b1011_0101, 8'b1101_1010);
        set_col(0, 1, 3'd3, 1'b0, 8'h0F, 8'hE1);
        set_col(0, 2, 3'd0, 1'b0, 8'hF0, 8'hF0);
        vecs[1].ncols = 5'd3;
        set_col(1, 0, 3'd1, 1'b0, 8'h81, 8'hC0);
        set_col(1, 1, 3'd5, 1'b1, 8'hFF, 8'h00);
        set_col(1, 2, 3'd7, 1'b0, 8'h01, 8'h02);
        vecs[2].ncols = 5'd4;
        set_col(2, 0, 3'd2, 1'b0, 8'h03, 8'hC0);
        set_col(2, 1, 3'd4, 1'b0, 8'h12, 8'h21);
        set_col(2, 2, 3'd6, 1'b0, 8'h80, 8'h02);
        set_col(2, 3, 3'd7, 1'b0, 8'hAA, 8'h55);
        vecs[3].ncols = 5'd2;
        set_col(3, 0, 3'd3, 1'b0, 8'hF1, 8'h3E);
        set_col(3, 1, 3'd1, 1'b0, 8'h7E, 8'h3F);
        vecs[4].ncols = 5'd8;
        set_col(4, 0, 3'd0, 1'b0, 8'hC3, 8'hC3);
        set_col(4, 1, 3'd1, 1'b0, 8'hC3, 8'hE1);
        set_col(4, 2, 3'd2, 1'b0, 8'hC3, 8'hF0);
        set_col(4, 3, 3'd3, 1'b0, 8'hC3, 8'h78);
        set_col(4, 4, 3'd4, 1'b0, 8'hC3, 8'h3C);
        set_col(4, 5, 3'd5, 1'b0, 8'hC3, 8'h1E);
        set_col(4, 6, 3'd6, 1'b0, 8'hC3, 8'h0F);
        set_col(4, 7, 3'd7, 1'b0, 8'hC3, 8'h87);
        vecs[5].ncols = 5'd1;
        set_col(5, 0, 3'd4, 1'b0, 8'h5A, 8'hA5);

        // Reset state
        repeat (3) tick();
        check("reset busy",      {31'd0, busy},      32'd0);
        check("reset done",      {31'd0, done},      32'd0);
        check("reset bm_rd",     {31'd0, bm_rd},     32'd0);
        check("reset res_valid", {31'd0, res_valid}, 32'd0);
        check("reset sh_in",     {24'd0, sh_in_data}, 32'd0);
        rst_n = 1'b1;
        tick();

        run_row(0, 1'b0, 0);

        // Zero-column row: done exactly two cycles after start, no reads
        base_rd  = bmrd_cnt;
        base_v   = valid_cnt;
        num_cols = 6'd0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        check("zero busy",      {31'd0, busy}, 32'd1);
        check("zero done early", {31'd0, done}, 32'd0);
        tick();
        check("zero done at 2", {31'd0, done}, 32'd1);
        check("zero busy low",  {31'd0, busy}, 32'd0);
        repeat (3) tick();
        check("zero no bm_rd",     32'(bmrd_cnt - base_rd), 32'd0);
        check("zero no res_valid", 32'(valid_cnt - base_v), 32'd0);

        run_row(1, 1'b0, 0);
        run_row(2, 1'b0, 0);
        run_row(5, 1'b0, 0);
        run_row(4, 1'b0, 40);
        run_row(0, 1'b1, 0);

        // Reset mid-row with three tokens in flight
        load_row(2);
        res_ready = 1'b1;
        num_cols  = 6'd4;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        check("midrst busy",      {31'd0, busy},      32'd0);
        check("midrst bm_rd",     {31'd0, bm_rd},     32'd0);
        check("midrst res_valid", {31'd0, res_valid}, 32'd0);
        check("midrst sh_in",     {24'd0, sh_in_data},   32'd0);
        check("midrst sh_shift",  {29'd0, sh_shift_val}, 32'd0);
        base_q = res_q.size();
        base_v = valid_cnt;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (30) tick();
        check("midrst no stale results", 32'(res_q.size() - base_q), 32'd0);
        check("midrst no stale valid",   32'(valid_cnt - base_v),   32'd0);
        run_row(3, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
